// File: rtl/riscv_pkg.sv
// Shared RV64 fetch types and constants.
// FETCH_MISALIGN_CHECK_EN adds a per-entry misalign flag to fetch_entry_t.
package riscv_pkg;
   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            filled;
`ifdef FETCH_MISALIGN_CHECK_EN
      logic            misalign;
`endif
   } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side handshakes of the fetch stage.
// FETCH_MISALIGN_CHECK_EN adds if_misalign_o.
interface fetch_unit_if;
   import riscv_pkg::*;

   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [ILEN-1:0] imem_rdata_i;
   logic            if_valid_o;
   logic            if_ready_i;
   logic [XLEN-1:0] if_pc_o;
   logic [ILEN-1:0] if_instr_o;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic            if_misalign_o;
`endif

   modport master (
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i,
`ifdef FETCH_MISALIGN_CHECK_EN
      output if_misalign_o,
`endif
      output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o
   );

   modport slave (
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i,
`ifdef FETCH_MISALIGN_CHECK_EN
      input  if_misalign_o,
`endif
      input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o
   );
endinterface

// File: rtl/fetch_queue.sv
// In-order fetch buffer with separate allocate, fill and pop pointers.
// Entries are allocated at request grant and filled later by in-order responses.
module fetch_queue
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    alloc_en,
   input  fetch_entry_t            alloc_entry,
   input  logic                    fill_en,
   input  logic [ILEN-1:0]         fill_data,
   input  logic                    pop,
   output logic [$clog2(DEPTH):0]  count,
   output fetch_entry_t            head
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   PTR_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] FILL_ONE = PW'(1);

   fetch_entry_t    entries [DEPTH];
   logic [PW:0]     alloc_ptr;
   logic [PW:0]     rd_ptr;
   logic [PW-1:0]   fill_ptr;

   assign count = alloc_ptr - rd_ptr;
   assign head  = entries[rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         alloc_ptr <= '0;
         rd_ptr    <= '0;
         fill_ptr  <= '0;
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else if (flush) begin
         alloc_ptr <= '0;
         rd_ptr    <= '0;
         fill_ptr  <= '0;
         for (int i = 0; i < DEPTH; i++) entries[i].filled <= 1'b0;
      end else begin
         if (alloc_en) begin
            entries[alloc_ptr[PW-1:0]] <= alloc_entry;
            alloc_ptr                  <= alloc_ptr + PTR_ONE;
         end
         if (fill_en) begin
            entries[fill_ptr].instr  <= fill_data;
            entries[fill_ptr].filled <= 1'b1;
            fill_ptr                 <= fill_ptr + FILL_ONE;
         end
         // clear on pop so an emptied queue never shows a previous lap's entry
         if (pop) begin
            entries[rd_ptr[PW-1:0]].filled <= 1'b0;
            rd_ptr                         <= rd_ptr + PTR_ONE;
         end
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem request issue, stale-response dropping.
// FETCH_MISALIGN_CHECK_EN turns a misaligned PC into a queued nop flagged misaligned.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              DEPTH    = 2
) (
   input  logic             clk,
   input  logic             rst,
   output logic [XLEN-1:0]  pc_o,
   input  logic [XLEN-1:0]  next_pc_i,
   input  logic             redirect_i,
   fetch_unit_if.master     bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   logic [XLEN-1:0] pc;
   logic [CW-1:0]   count, pend_cnt, drop_cnt;
   logic            has_space, req, grant, alloc_en, mis_alloc;
   logic            rsp_keep, rsp_drop, pop;
   fetch_entry_t    alloc_entry, head;

   assign has_space = !rst && !redirect_i && (count < CNT_MAX);

`ifdef FETCH_MISALIGN_CHECK_EN
   logic pc_misaligned, mis_hold;
   assign pc_misaligned = pc[1:0] != 2'b00;
   assign req           = has_space && !pc_misaligned;
   assign mis_alloc     = has_space && pc_misaligned && !mis_hold;

   // one nop per misaligned PC; fetch stays parked until a redirect
   always_ff @(posedge clk) begin
      if (rst || redirect_i) mis_hold <= 1'b0;
      else if (mis_alloc)    mis_hold <= 1'b1;
   end
`else
   assign req       = has_space;
   assign mis_alloc = 1'b0;
`endif

   assign grant    = req && bus.imem_gnt_i;
   assign alloc_en = grant || mis_alloc;
   assign rsp_drop = bus.imem_rvalid_i && (drop_cnt != '0);
   assign rsp_keep = bus.imem_rvalid_i && (drop_cnt == '0);
   assign pop      = head.filled && bus.if_ready_i && !redirect_i;

   always_comb begin
      alloc_entry        = '0;
      alloc_entry.pc     = pc;
      alloc_entry.instr  = mis_alloc ? NOP_INSTR : '0;
      alloc_entry.filled = mis_alloc;
`ifdef FETCH_MISALIGN_CHECK_EN
      alloc_entry.misalign = mis_alloc;
`endif
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk         (clk),
      .rst         (rst),
      .flush       (redirect_i),
      .alloc_en    (alloc_en),
      .alloc_entry (alloc_entry),
      .fill_en     (rsp_keep),
      .fill_data   (bus.imem_rdata_i),
      .pop         (pop),
      .count       (count),
      .head        (head)
   );

   // pend_cnt: granted, not yet answered, current epoch; drop_cnt: answers owed to flushed entries
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         pend_cnt <= '0;
         drop_cnt <= '0;
      end else if (redirect_i) begin
         pc       <= next_pc_i;
         pend_cnt <= '0;
         drop_cnt <= drop_cnt + pend_cnt - CW'(bus.imem_rvalid_i);
      end else begin
         if (grant) pc <= next_pc_i;
         pend_cnt <= pend_cnt + CW'(grant) - CW'(rsp_keep);
         if (rsp_drop) drop_cnt <= drop_cnt - CNT_ONE;
      end
   end

   assign pc_o            = pc;
   assign bus.imem_req_o  = req;
   assign bus.imem_addr_o = pc;
   assign bus.if_valid_o  = head.filled;
   assign bus.if_pc_o     = head.pc;
   assign bus.if_instr_o  = head.instr;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign bus.if_misalign_o = head.misalign;
`endif

   a_rsp_outstanding: assert property (@(posedge clk) disable iff (rst)
      bus.imem_rvalid_i |-> (pend_cnt != '0 || drop_cnt != '0));
   a_drop_bound: assert property (@(posedge clk) disable iff (rst)
      drop_cnt <= CNT_MAX);
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: epoch-tagged memory model plus expected decode stream.
module tb_fetch_unit;
   import riscv_pkg::*;

   localparam int          DEPTH  = 2;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] pc_o;
   logic [63:0] next_pc_i = '0;
   logic        redirect_i = 1'b0;

   fetch_unit_if bus();

   fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_o       (pc_o),
      .next_pc_i  (next_pc_i),
      .redirect_i (redirect_i),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   typedef struct { logic [63:0] pc; bit ready; } dq_t;
   typedef struct { logic [63:0] addr; int epoch; int due; } mq_t;

   dq_t         dq[$];   // instructions decode must see, oldest first
   mq_t         mq[$];   // memory's in-flight responses
   logic [63:0] pc_m;
   int          epoch, cyc, last_due;
   int          n_cmp, n_fail;
   int          gnt_pct, rdy_pct, redir_pct, lat_min, lat_max;
   bit          model_on, force_redir;
   logic [63:0] force_tgt;

   logic [63:0] s_pc, s_addr, s_if_pc;
   logic [31:0] s_instr;
   bit          s_req, s_valid, s_gnt, s_mis;

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_k(input int g, input int r, input int rd, input int lmin, input int lmax);
      gnt_pct = g; rdy_pct = r; redir_pct = rd; lat_min = lmin; lat_max = lmax;
   endtask

   task automatic do_cycle(input bit r);
      bit          rd, g, rv, rdy, exp_req, exp_valid;
      logic [63:0] tgt;
      int          due;
      mq_t         m;
      @(negedge clk);
      rst = r;
      rd  = !r && (force_redir || ($urandom_range(0, 99) < redir_pct));
      if (force_redir)                 tgt = force_tgt;
      else if ($urandom_range(0, 19) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF8;
      else                             tgt = RST_PC + (64'($urandom_range(0, 255)) << 2);
      force_redir = 1'b0;
      redirect_i  = rd;
      next_pc_i   = rd ? tgt : pc_m + 64'd4;
      exp_req     = !r && !rd && (dq.size() < DEPTH);
      g   = !r && (mq.size() < DEPTH) && ($urandom_range(0, 99) < gnt_pct);
      rv  = !r && (mq.size() > 0) && (mq[0].due <= cyc);
      rdy = $urandom_range(0, 99) < rdy_pct;
      bus.imem_gnt_i    = g;
      bus.imem_rvalid_i = rv;
      bus.imem_rdata_i  = rv ? instr_of(mq[0].addr) : 32'($urandom);
      bus.if_ready_i    = rdy;
      #1;
      s_pc = pc_o; s_addr = bus.imem_addr_o; s_req = bus.imem_req_o;
      s_valid = bus.if_valid_o; s_if_pc = bus.if_pc_o; s_instr = bus.if_instr_o;
      s_gnt = s_req && g;
`ifdef FETCH_MISALIGN_CHECK_EN
      s_mis = bus.if_misalign_o;
`else
      s_mis = 1'b0;
`endif
      exp_valid = (dq.size() > 0) && dq[0].ready;
      if (model_on) begin
         chk("imem_req", 64'(s_req), 64'(exp_req));
         if (!r) begin
            chk("pc_o", s_pc, pc_m);
            chk("imem_addr", s_addr, pc_m);
            chk("if_valid", 64'(s_valid), 64'(exp_valid));
            if (exp_valid) begin
               chk("if_pc", s_if_pc, dq[0].pc);
               chk("if_instr", 64'(s_instr), 64'(instr_of(dq[0].pc)));
            end
         end
      end
      if (r) begin
         pc_m = RST_PC; dq.delete(); mq.delete(); epoch++;
      end else begin
         if (rv) begin
            m = mq.pop_front();
            if (m.epoch == epoch && !rd) begin
               for (int i = 0; i < dq.size(); i++)
                  if (!dq[i].ready) begin dq[i].ready = 1'b1; break; end
            end
         end
         if (rd) begin
            dq.delete(); epoch++; pc_m = tgt;
         end else begin
            if (exp_valid && rdy) void'(dq.pop_front());
            if (exp_req && g) begin
               due = cyc + $urandom_range(lat_min, lat_max);
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               dq.push_back('{pc_m, 1'b0});
               mq.push_back('{pc_m, epoch, due});
               pc_m = pc_m + 64'd4;
            end
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      do_cycle(1'b1);
      do_cycle(1'b1);
   endtask

   initial begin
      bit found;
      int grants;
      n_cmp = 0; n_fail = 0; epoch = 0; cyc = 0; last_due = 0;
      pc_m = RST_PC; model_on = 1'b1; force_redir = 1'b0; force_tgt = '0;
      bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0; bus.if_ready_i = 1'b0;

      // streaming: grant always, 1-cycle latency, decode always ready
      set_k(100, 100, 0, 1, 1);
      do_reset();
      do_cycle(1'b0);
      chk("rst_pc", s_pc, 64'h8000_0000);
      chk("rst_valid", 64'(s_valid), 64'd0);
      chk("rst_if_pc", s_if_pc, 64'd0);
      chk("rst_if_instr", 64'(s_instr), 64'd0);
      chk("first_req", 64'(s_req), 64'd1);
      do_cycle(1'b0);
      chk("second_addr", s_addr, 64'h8000_0004);
      chk("valid_lat1", 64'(s_valid), 64'd0);
      do_cycle(1'b0);
      chk("valid_lat2", 64'(s_valid), 64'd1);
      chk("first_if_pc", s_if_pc, 64'h8000_0000);
      chk("full_no_req", 64'(s_req), 64'd0);
      do_cycle(1'b0);
      chk("second_if_pc", s_if_pc, 64'h8000_0004);
      for (int i = 0; i < 10; i++) do_cycle(1'b0);

      // backpressure: exactly DEPTH grants, then release
      set_k(100, 0, 0, 1, 1);
      do_reset();
      grants = 0;
      for (int i = 0; i < 8; i++) begin do_cycle(1'b0); grants += int'(s_gnt); end
      chk("bp_grants", 64'(grants), 64'd2);
      chk("bp_req_held", 64'(s_req), 64'd0);
      set_k(100, 100, 0, 1, 1);
      do_cycle(1'b0);
      chk("pop_no_same_req", 64'(s_req), 64'd0);
      chk("pop_head", s_if_pc, 64'h8000_0000);
      do_cycle(1'b0);
      chk("req_after_pop", 64'(s_req), 64'd1);
      chk("req_after_pop_addr", s_addr, 64'h8000_0008);
      for (int i = 0; i < 6; i++) do_cycle(1'b0);

      // redirect with two outstanding
      set_k(100, 0, 0, 4, 4);
      do_reset();
      do_cycle(1'b0);
      do_cycle(1'b0);
      force_redir = 1'b1; force_tgt = 64'h8000_0100;
      do_cycle(1'b0);
      chk("redir_no_req", 64'(s_req), 64'd0);
      set_k(100, 100, 0, 4, 4);
      do_cycle(1'b0);
      chk("redir_addr", s_addr, 64'h8000_0100);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin do_cycle(1'b0); found = s_valid; end
      chk("redir_valid_seen", 64'(found), 64'd1);
      chk("redir_first_pc", s_if_pc, 64'h8000_0100);

      // redirect coinciding with the only response
      set_k(100, 100, 0, 1, 1);
      do_reset();
      do_cycle(1'b0);
      set_k(0, 100, 0, 1, 1);
      force_redir = 1'b1; force_tgt = 64'h8000_0200;
      do_cycle(1'b0);
      set_k(100, 100, 0, 1, 1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin do_cycle(1'b0); found = s_valid; end
      chk("rv_redir_seen", 64'(found), 64'd1);
      chk("rv_redir_first_pc", s_if_pc, 64'h8000_0200);

      // reset with a full queue
      set_k(100, 0, 0, 1, 1);
      do_reset();
      for (int i = 0; i < 6; i++) do_cycle(1'b0);
      do_cycle(1'b1);
      chk("midrst_req", 64'(s_req), 64'd0);
      do_cycle(1'b0);
      chk("midrst_pc", s_pc, RST_PC);
      chk("midrst_valid", 64'(s_valid), 64'd0);

      // PC wraps past 2^64
      set_k(100, 100, 0, 1, 2);
      force_redir = 1'b1; force_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
      do_cycle(1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin do_cycle(1'b0); found = s_gnt && (s_addr == 64'd0); end
      chk("wrap_grant_at_0", 64'(found), 64'd1);
      for (int i = 0; i < 8; i++) do_cycle(1'b0);

      // randomized traffic
      for (int blk = 0; blk < 16; blk++) begin
         set_k($urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(0, 15), 1, $urandom_range(1, 4));
         for (int i = 0; i < 250; i++) do_cycle($urandom_range(0, 499) == 0);
      end

`ifdef FETCH_MISALIGN_CHECK_EN
      set_k(0, 0, 0, 1, 1);
      do_reset();
      model_on = 1'b0;
      force_redir = 1'b1; force_tgt = 64'h8000_0102;
      do_cycle(1'b0);
      do_cycle(1'b0);
      chk("mis_no_req", 64'(s_req), 64'd0);
      do_cycle(1'b0);
      chk("mis_valid", 64'(s_valid), 64'd1);
      chk("mis_flag", 64'(s_mis), 64'd1);
      chk("mis_instr", 64'(s_instr), 64'h13);
      chk("mis_pc", s_if_pc, 64'h8000_0102);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
